// File: rtl/pc_proto_pkg.sv
// Protocol constants shared by the PC link receive and transmit sides:
// sync pattern, frame type base and parser state encodings.
package pc_proto_pkg;

    localparam logic [7:0]  SYNC_B0   = 8'hEF;
    localparam logic [7:0]  SYNC_B1   = 8'h91;
    localparam logic [7:0]  SYNC_B2   = 8'h19;
    localparam logic [7:0]  SYNC_B3   = 8'hFE;
    localparam logic [15:0] TYPE_BASE = 16'h4000;

    typedef enum logic [2:0] {
        ST_HUNT = 3'd0,
        ST_TYPE = 3'd1,
        ST_DATA = 3'd2,
        ST_CRC  = 3'd3,
        ST_DONE = 3'd4
    } pc_state_e;

    function automatic logic [7:0] sync_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = SYNC_B0;
            2'd1:    b = SYNC_B1;
            2'd2:    b = SYNC_B2;
            2'd3:    b = SYNC_B3;
            default: b = SYNC_B0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/cb_crc32.sv
// Byte-wide CRC-32 (reflected 0xEDB88320, init all-ones, final inversion).
// crc_data always holds the finished CRC of the bytes fed since the last clear.
module cb_crc32 (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        crc_clear,
    input  logic [7:0]  src_data,
    input  logic        src_data_valid,
    output logic [31:0] crc_data
);

    function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if ((c[0] ^ data[i]) == 1'b1) begin
                c = (c >> 1) ^ 32'hEDB88320;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    logic [31:0] base_s;

    // Clear restarts from the all-ones seed; a byte fed in the same cycle folds into the seed.
    always_comb begin
        if (crc_clear) begin
            base_s = 32'hFFFF_FFFF;
        end else begin
            base_s = ~crc_data;
        end
    end

    // Stored value is the inverted state so that reset to zero equals a cleared engine.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            crc_data <= 32'h0000_0000;
        end else if (src_data_valid) begin
            crc_data <= ~crc32_step(base_s, src_data);
        end else if (crc_clear) begin
            crc_data <= 32'h0000_0000;
        end else begin
            crc_data <= crc_data;
        end
    end

endmodule

// File: rtl/pc_rx_frame.sv
// PC link frame receiver: sync hunt, type decode, per-channel payload strobes, CRC-32 verdict.
// Define PC_RX_TIMEOUT_EN to abort stalled frames after TIMEOUT_CYC idle cycles.
module pc_rx_frame
    import pc_proto_pkg::*;
#(
    parameter int          U_DLY       = 32'sd1,
    parameter logic [15:0] LEN0        = 16'd16,
    parameter logic [15:0] LEN1        = 16'd16,
    parameter logic [15:0] LEN2        = 16'd16,
    parameter logic [15:0] LEN3        = 16'd16,
    parameter logic [15:0] TIMEOUT_CYC = 16'd1000
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic [7:0]  pc_rx_data,
    input  logic        pc_rx_data_valid,
    output logic [3:0]  pkg_rx_en,
    output logic [7:0]  pkg_rx_data,
    output logic [3:0]  pkg_rx_done,
    output logic        pkg_rx_crc_ok,
    output logic [15:0] frm_ok_cnt,
    output logic [15:0] frm_err_cnt
);

    pc_state_e   state_r, state_s;
    logic [1:0]  sync_idx_r, sync_idx_s;
    logic        type_sel_r;
    logic [7:0]  type_hi_r;
    logic [1:0]  chan_r;
    logic [15:0] len_r, len_sel_s;
    logic [15:0] byte_cnt_r;
    logic [31:0] rx_crc_r;
    logic [31:0] calc_crc_s;
    logic        hunt_match_s, hunt_clear_s, hunt_feed_s, type_good_s;
    logic [1:0]  hunt_idx_s;
    logic        crc_clear_s, crc_feed_s, fwd_s, done_s, crc_ok_s, ok_inc_s, err_inc_s;
    logic        timeout_s;
    logic        cfg_unused_s;

    cb_crc32 u_crc (
        .clk_sys        (clk_sys),
        .rst_n          (rst_n),
        .crc_clear      (crc_clear_s),
        .src_data       (pc_rx_data),
        .src_data_valid (crc_feed_s),
        .crc_data       (calc_crc_s)
    );

`ifdef PC_RX_TIMEOUT_EN
    logic [15:0] idle_cnt_r;

    // Abort fires on the TIMEOUT_CYC-th consecutive idle cycle inside a frame.
    always_comb begin
        timeout_s = (state_r inside {ST_TYPE, ST_DATA, ST_CRC}) && !pc_rx_data_valid &&
                    (idle_cnt_r == TIMEOUT_CYC - 16'd1);
    end

    // Idle cycle counter, restarted by every byte and whenever no frame is open.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_r <= 16'd0;
        end else if (pc_rx_data_valid || timeout_s || state_r == ST_HUNT || state_r == ST_DONE) begin
            idle_cnt_r <= 16'd0;
        end else begin
            idle_cnt_r <= idle_cnt_r + 16'd1;
        end
    end

    assign cfg_unused_s = (U_DLY != 32'sd0);
`else
    assign timeout_s    = 1'b0;
    assign cfg_unused_s = (U_DLY != 32'sd0) ^ (|TIMEOUT_CYC);
`endif

    // Sync matcher, type decode and payload length lookup for the incoming byte.
    always_comb begin
        hunt_match_s = (pc_rx_data == sync_byte(sync_idx_r));
        if (hunt_match_s) begin
            hunt_idx_s = sync_idx_r + 2'd1;
        end else if (pc_rx_data == SYNC_B0) begin
            hunt_idx_s = 2'd1;
        end else begin
            hunt_idx_s = 2'd0;
        end
        // Any byte that does not extend a partial sync restarts the CRC.
        hunt_clear_s = !(hunt_match_s && sync_idx_r != 2'd0);
        hunt_feed_s  = hunt_match_s || (pc_rx_data == SYNC_B0);
        type_good_s  = ({type_hi_r, pc_rx_data[7:2], 2'b00} == TYPE_BASE);
        case (pc_rx_data[1:0])
            2'd0:    len_sel_s = LEN0;
            2'd1:    len_sel_s = LEN1;
            2'd2:    len_sel_s = LEN2;
            2'd3:    len_sel_s = LEN3;
            default: len_sel_s = LEN0;
        endcase
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_s     = state_r;
        sync_idx_s  = sync_idx_r;
        crc_clear_s = 1'b0;
        crc_feed_s  = 1'b0;
        fwd_s       = 1'b0;
        done_s      = 1'b0;
        crc_ok_s    = 1'b0;
        ok_inc_s    = 1'b0;
        err_inc_s   = 1'b0;
        case (state_r)
            ST_HUNT: begin
                if (pc_rx_data_valid) begin
                    sync_idx_s  = hunt_idx_s;
                    crc_clear_s = hunt_clear_s;
                    crc_feed_s  = hunt_feed_s;
                    if (hunt_match_s && sync_idx_r == 2'd3) begin
                        state_s = ST_TYPE;
                    end else begin
                        state_s = ST_HUNT;
                    end
                end else begin
                    state_s = ST_HUNT;
                end
            end
            ST_TYPE: begin
                if (pc_rx_data_valid) begin
                    crc_feed_s = 1'b1;
                    if (!type_sel_r) begin
                        state_s = ST_TYPE;
                    end else if (type_good_s) begin
                        state_s = ST_DATA;
                    end else begin
                        state_s   = ST_HUNT;
                        err_inc_s = 1'b1;
                    end
                end else if (timeout_s) begin
                    state_s   = ST_HUNT;
                    err_inc_s = 1'b1;
                end else begin
                    state_s = ST_TYPE;
                end
            end
            ST_DATA: begin
                if (pc_rx_data_valid) begin
                    crc_feed_s = 1'b1;
                    fwd_s      = 1'b1;
                    if (byte_cnt_r + 16'd1 == len_r) begin
                        state_s = ST_CRC;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else if (timeout_s) begin
                    state_s   = ST_HUNT;
                    err_inc_s = 1'b1;
                    done_s    = 1'b1;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_CRC: begin
                if (pc_rx_data_valid) begin
                    if (type_sel_r == 1'b0 && rx_crc_idx_last(byte_cnt_r)) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_CRC;
                    end
                end else if (timeout_s) begin
                    state_s   = ST_HUNT;
                    err_inc_s = 1'b1;
                    done_s    = 1'b1;
                end else begin
                    state_s = ST_CRC;
                end
            end
            ST_DONE: begin
                done_s    = 1'b1;
                crc_ok_s  = (rx_crc_r == calc_crc_s);
                ok_inc_s  = crc_ok_s;
                err_inc_s = !crc_ok_s;
                state_s   = ST_HUNT;
                // The byte of this cycle already belongs to the next hunt.
                if (pc_rx_data_valid) begin
                    sync_idx_s  = hunt_idx_s;
                    crc_clear_s = hunt_clear_s;
                    crc_feed_s  = hunt_feed_s;
                end else begin
                    sync_idx_s = sync_idx_r;
                end
            end
            default: begin
                state_s    = ST_HUNT;
                sync_idx_s = 2'd0;
            end
        endcase
    end

    // CRC byte position reuses the payload counter: it counts on to len_r + 3.
    function automatic logic rx_crc_idx_last(input logic [15:0] cnt);
        return (cnt == len_r + 16'd3);
    endfunction

    // FSM state register.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_HUNT;
        end else begin
            state_r <= state_s;
        end
    end

    // Frame context: sync index, type, channel, length, byte counter, received CRC.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sync_idx_r <= 2'd0;
            type_sel_r <= 1'b0;
            type_hi_r  <= 8'd0;
            chan_r     <= 2'd0;
            len_r      <= 16'd0;
            byte_cnt_r <= 16'd0;
            rx_crc_r   <= 32'd0;
        end else begin
            sync_idx_r <= sync_idx_s;
            case (state_r)
                ST_HUNT: begin
                    type_sel_r <= 1'b0;
                end
                ST_TYPE: begin
                    if (pc_rx_data_valid) begin
                        type_sel_r <= !type_sel_r;
                        if (!type_sel_r) begin
                            type_hi_r <= pc_rx_data;
                        end else begin
                            chan_r     <= pc_rx_data[1:0];
                            len_r      <= len_sel_s;
                            byte_cnt_r <= 16'd0;
                        end
                    end
                end
                ST_DATA, ST_CRC: begin
                    if (pc_rx_data_valid) begin
                        byte_cnt_r <= byte_cnt_r + 16'd1;
                        if (state_r == ST_CRC) begin
                            rx_crc_r <= {rx_crc_r[23:0], pc_rx_data};
                        end
                    end
                end
                default: begin
                    type_sel_r <= 1'b0;
                end
            endcase
        end
    end

    // Registered payload strobes, end-of-frame verdict and saturating frame counters.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            pkg_rx_en     <= 4'd0;
            pkg_rx_data   <= 8'd0;
            pkg_rx_done   <= 4'd0;
            pkg_rx_crc_ok <= 1'b0;
            frm_ok_cnt    <= 16'd0;
            frm_err_cnt   <= 16'd0;
        end else begin
            pkg_rx_en     <= fwd_s ? (4'b0001 << chan_r) : 4'b0000;
            pkg_rx_done   <= done_s ? (4'b0001 << chan_r) : 4'b0000;
            pkg_rx_crc_ok <= done_s & crc_ok_s;
            if (fwd_s) begin
                pkg_rx_data <= pc_rx_data;
            end
            if (ok_inc_s && frm_ok_cnt != 16'hFFFF) begin
                frm_ok_cnt <= frm_ok_cnt + 16'd1;
            end
            if (err_inc_s && frm_err_cnt != 16'hFFFF) begin
                frm_err_cnt <= frm_err_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pc_rx_frame.sv
// Directed bench for pc_rx_frame: good/bad CRC, sync slip, bad type, back-to-back,
// gapped bytes, stall (timeout when PC_RX_TIMEOUT_EN is defined) and mid-frame reset.
module tb_pc_rx_frame;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic [7:0]  pc_rx_data;
    logic        pc_rx_data_valid;
    logic [3:0]  pkg_rx_en;
    logic [7:0]  pkg_rx_data;
    logic [3:0]  pkg_rx_done;
    logic        pkg_rx_crc_ok;
    logic [15:0] frm_ok_cnt;
    logic [15:0] frm_err_cnt;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_strobe_cyc = 0;
    logic [7:0]  fq[$];
    logic [7:0]  tail[$];
    logic [11:0] en_q[$];
    logic [4:0]  done_q[$];
    int          done_cyc_q[$];

    pc_rx_frame #(.TIMEOUT_CYC(16'd100)) dut (
        .clk_sys          (clk_sys),
        .rst_n            (rst_n),
        .pc_rx_data       (pc_rx_data),
        .pc_rx_data_valid (pc_rx_data_valid),
        .pkg_rx_en        (pkg_rx_en),
        .pkg_rx_data      (pkg_rx_data),
        .pkg_rx_done      (pkg_rx_done),
        .pkg_rx_crc_ok    (pkg_rx_crc_ok),
        .frm_ok_cnt       (frm_ok_cnt),
        .frm_err_cnt      (frm_err_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk_sys) begin
        if (rst_n) begin
            if (pkg_rx_en != 4'd0) en_q.push_back({pkg_rx_en, pkg_rx_data});
            if (pkg_rx_done != 4'd0) begin
                done_q.push_back({pkg_rx_done, pkg_rx_crc_ok});
                done_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_crc(input int lo, input int hi);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = lo; i < hi; i++) begin
            c = c ^ {24'h0, fq[i]};
            for (int b = 0; b < 8; b++) c = (c >> 1) ^ (32'hEDB88320 & {32{c[0]}});
        end
        return ~c;
    endfunction

    task automatic push_hdr(input logic [15:0] typ);
        fq.push_back(8'hEF); fq.push_back(8'h91); fq.push_back(8'h19); fq.push_back(8'hFE);
        fq.push_back(typ[15:8]); fq.push_back(typ[7:0]);
    endtask

    task automatic build_frame(input logic [15:0] typ, input logic [7:0] crc_xor);
        int s;
        logic [31:0] c;
        s = fq.size();
        push_hdr(typ);
        for (int i = 0; i < 16; i++) fq.push_back(i[7:0]);
        c = ref_crc(s, fq.size());
        fq.push_back(c[31:24]); fq.push_back(c[23:16]); fq.push_back(c[15:8]);
        fq.push_back(c[7:0] ^ crc_xor);
    endtask

    task automatic send_q(input int gap);
        for (int i = 0; i < fq.size(); i++) begin
            @(negedge clk_sys);
            pc_rx_data = fq[i];
            pc_rx_data_valid = 1'b1;
            last_strobe_cyc = cyc;
            if (gap != 0) begin
                repeat (i % 3) begin
                    @(negedge clk_sys);
                    pc_rx_data_valid = 1'b0;
                end
            end
        end
        @(negedge clk_sys);
        pc_rx_data_valid = 1'b0;
        fq.delete();
        repeat (4) @(negedge clk_sys);
    endtask

    task automatic clear_mon();
        en_q.delete(); done_q.delete(); done_cyc_q.delete();
    endtask

    task automatic check_frame(input string tag, input logic [1:0] ch, input logic exp_ok,
                               input logic [15:0] ok_c, input logic [15:0] err_c);
        logic [3:0] oh;
        oh = 4'b0001 << ch;
        chk_val({tag, "/n_bytes"}, 32'(en_q.size()), 32'd16);
        for (int i = 0; i < 16 && i < en_q.size(); i++)
            chk_val({tag, "/byte"}, {20'd0, en_q[i]}, {20'd0, oh, i[7:0]});
        chk_val({tag, "/n_done"}, 32'(done_q.size()), 32'd1);
        if (done_q.size() > 0) begin
            chk_val({tag, "/done"}, {28'd0, done_q[0][4:1]}, {28'd0, oh});
            chk_val({tag, "/crc_ok"}, {31'd0, done_q[0][0]}, {31'd0, exp_ok});
            chk_val({tag, "/latency"}, done_cyc_q[0] - last_strobe_cyc, 32'd2);
        end
        chk_val({tag, "/ok_cnt"}, {16'd0, frm_ok_cnt}, {16'd0, ok_c});
        chk_val({tag, "/err_cnt"}, {16'd0, frm_err_cnt}, {16'd0, err_c});
        clear_mon();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        pc_rx_data = 8'd0;
        pc_rx_data_valid = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk_val("rst/en", {28'd0, pkg_rx_en}, 32'd0);
        chk_val("rst/done", {28'd0, pkg_rx_done}, 32'd0);
        chk_val("rst/crc_ok", {31'd0, pkg_rx_crc_ok}, 32'd0);
        chk_val("rst/cnts", {frm_ok_cnt, frm_err_cnt}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        build_frame(16'h4002, 8'h00); send_q(0);
        check_frame("good_4002", 2'd2, 1'b1, 16'd1, 16'd0);

        build_frame(16'h4002, 8'h01); send_q(0);
        check_frame("badcrc_4002", 2'd2, 1'b0, 16'd1, 16'd1);

        fq.push_back(8'hEF); build_frame(16'h4000, 8'h00); send_q(0);
        check_frame("extra_ef", 2'd0, 1'b1, 16'd2, 16'd1);

        push_hdr(16'h4105); send_q(0);
        chk_val("type4105/en", 32'(en_q.size()), 32'd0);
        chk_val("type4105/done", 32'(done_q.size()), 32'd0);
        chk_val("type4105/err_cnt", {16'd0, frm_err_cnt}, 32'd2);
        build_frame(16'h4001, 8'h00); send_q(0);
        check_frame("after_bad_type", 2'd1, 1'b1, 16'd3, 16'd2);

        push_hdr(16'h4004); send_q(0);
        chk_val("type4004/done", 32'(done_q.size()), 32'd0);
        chk_val("type4004/err_cnt", {16'd0, frm_err_cnt}, 32'd3);

        build_frame(16'h4001, 8'h00); build_frame(16'h4003, 8'h00); send_q(0);
        chk_val("b2b/n_bytes", 32'(en_q.size()), 32'd32);
        chk_val("b2b/n_done", 32'(done_q.size()), 32'd2);
        if (done_q.size() == 2) begin
            chk_val("b2b/done0", {27'd0, done_q[0]}, 32'b00101);
            chk_val("b2b/done1", {27'd0, done_q[1]}, 32'b10001);
        end
        chk_val("b2b/ok_cnt", {16'd0, frm_ok_cnt}, 32'd5);
        clear_mon();

        build_frame(16'h4003, 8'h00); send_q(1);
        check_frame("gaps", 2'd3, 1'b1, 16'd6, 16'd3);

        build_frame(16'h4002, 8'h00);
        tail = fq[11:$];
        fq = fq[0:10];
        for (int i = 0; i < fq.size(); i++) begin
            @(negedge clk_sys); pc_rx_data = fq[i]; pc_rx_data_valid = 1'b1;
        end
        fq.delete();
        @(negedge clk_sys); pc_rx_data_valid = 1'b0;
        repeat (98) @(negedge clk_sys);
        chk_val("stall/no_early_done", 32'(done_q.size()), 32'd0);
        repeat (3) @(negedge clk_sys);
`ifdef PC_RX_TIMEOUT_EN
        chk_val("timeout/n_done", 32'(done_q.size()), 32'd1);
        if (done_q.size() > 0) chk_val("timeout/done", {27'd0, done_q[0]}, 32'b01000);
        chk_val("timeout/n_bytes", 32'(en_q.size()), 32'd5);
        chk_val("timeout/err_cnt", {16'd0, frm_err_cnt}, 32'd4);
        clear_mon();
        build_frame(16'h4000, 8'h00); send_q(0);
        check_frame("after_timeout", 2'd0, 1'b1, 16'd7, 16'd4);
`else
        repeat (50) @(negedge clk_sys);
        chk_val("stall/no_done", 32'(done_q.size()), 32'd0);
        fq = tail; send_q(0);
        check_frame("stall_resume", 2'd2, 1'b1, 16'd7, 16'd3);
`endif

        build_frame(16'h4001, 8'h00);
        tail = fq[11:$];
        fq = fq[0:10];
        for (int i = 0; i < fq.size(); i++) begin
            @(negedge clk_sys); pc_rx_data = fq[i]; pc_rx_data_valid = 1'b1;
        end
        fq.delete();
        @(posedge clk_sys);
        #2;
        rst_n = 1'b0;
        pc_rx_data_valid = 1'b0;
        #1;
        chk_val("async_rst/en", {28'd0, pkg_rx_en}, 32'd0);
        chk_val("async_rst/data", {24'd0, pkg_rx_data}, 32'd0);
        chk_val("async_rst/cnts", {frm_ok_cnt, frm_err_cnt}, 32'd0);
        @(negedge clk_sys);
        rst_n = 1'b1;
        clear_mon();
        fq = tail; send_q(0);
        chk_val("rst_mid/en", 32'(en_q.size()), 32'd0);
        chk_val("rst_mid/done", 32'(done_q.size()), 32'd0);
        chk_val("rst_mid/cnts", {frm_ok_cnt, frm_err_cnt}, 32'd0);
        clear_mon();
        build_frame(16'h4000, 8'h00); send_q(0);
        check_frame("after_rst", 2'd0, 1'b1, 16'd1, 16'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pc_rx_frame.md
PC_RX_FRAME -- requirements
Module: pc_rx_frame

Interface
REQ-001 SHALL have parameter U_DLY, default 1, register update delay in ns.
REQ-002 SHALL have parameters LEN0..LEN3, default 16'd16 each, fixed payload byte count for frame types 0x4000..0x4003 (legal range 1..65535).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 16'd1000, inter-byte timeout in clk_sys cycles.
REQ-004 SHALL have clk_sys, input, 1, the single system clock.
REQ-005 SHALL have rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have pc_rx_data, input, 8, received PC byte.
REQ-007 SHALL have pc_rx_data_valid, input, 1, byte strobe, one byte per high cycle.
REQ-008 SHALL have pkg_rx_en, output, 4, one-hot payload byte strobe per channel.
REQ-009 SHALL have pkg_rx_data, output, 8, payload byte, shared by all channels.
REQ-010 SHALL have pkg_rx_done, output, 4, one-cycle end-of-frame pulse per channel.
REQ-011 SHALL have pkg_rx_crc_ok, output, 1, frame verdict, valid while pkg_rx_done is non-zero.
REQ-012 SHALL have frm_ok_cnt, output, 16, count of good frames.
REQ-013 SHALL have frm_err_cnt, output, 16, count of bad or aborted frames.

Function
REQ-014 SHALL parse frames of the form EF 91 19 FE, TYPE_H, TYPE_L, payload (LENn bytes), CRC32 in 4 bytes MSB first.
REQ-015 SHALL use FSM states HUNT, TYPE, DATA, CRC, DONE; reset state HUNT.
REQ-016 HUNT SHALL track a 2-bit sync index; on a match, advance; on a mismatch, set index to 1 if the byte is EF, else 0; after FE go to TYPE.
REQ-017 TYPE SHALL accept 2 bytes; TYPE_H=0x40 and TYPE_L in 0x00..0x03 latch channel=TYPE_L[1:0] and go to DATA.
REQ-018 Any other type value SHALL return to HUNT, increment frm_err_cnt, and produce no pkg_rx_done pulse.
REQ-019 DATA SHALL forward each byte on pkg_rx_data with pkg_rx_en[channel] high, one cycle after the input byte.
REQ-020 DATA SHALL go to CRC after exactly LENn bytes, counted by a 16-bit counter.
REQ-021 CRC SHALL collect 4 bytes into a 32-bit register MSB first, then go to DONE.
REQ-022 The CRC engine SHALL be cleared in HUNT and SHALL be fed the 4 sync bytes, 2 type bytes and all payload bytes, but not the CRC bytes.
REQ-023 DONE SHALL last one cycle: pkg_rx_done[channel]=1, pkg_rx_crc_ok=(received CRC == computed CRC), then return to HUNT.
REQ-024 The pkg_rx_done pulse SHALL occur exactly 2 cycles after the 4th CRC byte's strobe.
REQ-025 A byte arriving in the DONE cycle SHALL be treated as the first byte of HUNT, with no byte loss.
REQ-026 frm_ok_cnt and frm_err_cnt SHALL saturate at 16'hFFFF.
REQ-027 Gaps of any length between valid bytes SHALL be allowed; the FSM SHALL hold state while pc_rx_data_valid is low.

Reset
REQ-028 On rst_n low, all outputs SHALL be 0, the FSM SHALL be in HUNT, and all counters and registers SHALL be 0, immediately and asynchronously.
REQ-029 Reset mid-frame SHALL discard the frame with no done pulse and no count change after release.

Configuration
REQ-030 With PC_RX_TIMEOUT_EN defined, TIMEOUT_CYC cycles without a valid byte outside HUNT SHALL abort the frame to HUNT and increment frm_err_cnt.
REQ-031 When that abort happens in DATA or CRC, it SHALL also pulse pkg_rx_done[channel] with pkg_rx_crc_ok=0.
REQ-032 Without PC_RX_TIMEOUT_EN, there SHALL be no timeout counter and the FSM SHALL wait indefinitely.

Structure
REQ-033 Sync bytes, the type base 16'h4000 and the FSM state encodings SHALL live in shared package pc_proto_pkg, shared with the transmit side.
REQ-034 CRC SHALL be computed by the existing cb_crc32 sub-module (crc_clear, src_data, src_data_valid, crc_data); no other sub-module.

Verification
REQ-035 Frame type 0x4002, 16 payload bytes 00..0F, correct CRC -> pkg_rx_en[2] strobes 16 bytes 00..0F; pkg_rx_done=4'b0100; crc_ok=1; frm_ok_cnt=1.
REQ-036 Same frame with last CRC byte XOR 0x01 -> pkg_rx_done=4'b0100; crc_ok=0; frm_err_cnt=1.
REQ-037 Stream EF EF 91 19 FE 40 00 ... (valid frame) -> frame received on channel 0; the leading extra EF is tolerated.
REQ-038 Type 0x4105 after sync -> no pkg_rx_en, no done; frm_err_cnt=1; the next valid frame is received correctly.
REQ-039 Two back-to-back valid frames (types 0x4001 then 0x4003) with no gap -> two done pulses, 4'b0010 then 4'b1000; frm_ok_cnt=2.
REQ-040 With PC_RX_TIMEOUT_EN and TIMEOUT_CYC=100, stall 100 cycles after the 5th payload byte -> done pulse with crc_ok=0; frm_err_cnt=1; FSM in HUNT.
